// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with a running XOR accumulator and
// valid/ready handshakes on both sides.
module logic_unit_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] OP_ACC = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_parity;

    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_op_count;

    logic             w_adv2;
    logic             w_mv12;
    logic             w_in_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [WIDTH-1:0] w_res;

    // S2 can take new data when empty or draining this edge; S1 likewise when S2 advances.
    assign w_adv2     = !r_s2_valid || out_ready;
    assign w_mv12     = r_s1_valid && w_adv2;
    assign w_in_ready = !r_s1_valid || w_adv2;
    assign w_in_xfer  = in_valid && w_in_ready;
    assign w_out_xfer = r_s2_valid && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic w_bit;
            always_comb begin
                w_bit = 1'b0;
                case (r_s1_op)
                    3'b000:  w_bit = r_s1_a[gi] & r_s1_b[gi];
                    3'b001:  w_bit = r_s1_a[gi] | r_s1_b[gi];
                    3'b010:  w_bit = r_s1_a[gi] ^ r_s1_b[gi];
                    3'b011:  w_bit = ~(r_s1_a[gi] & r_s1_b[gi]);
                    3'b100:  w_bit = ~(r_s1_a[gi] | r_s1_b[gi]);
                    3'b101:  w_bit = ~(r_s1_a[gi] ^ r_s1_b[gi]);
                    OP_ACC:  w_bit = r_acc[gi] ^ r_s1_a[gi];
                    default: w_bit = 1'b0;
                endcase
            end
            assign w_res[gi] = w_bit;
        end
    endgenerate

    // Operands are captured only on a real transfer, so idle-cycle X never enters the pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= 3'b000;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= a;
            r_s1_b     <= b;
            r_s1_op    <= op;
        end else if (w_mv12) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_parity   <= 1'b0;
        end else if (w_mv12) begin
            r_s2_valid <= 1'b1;
            r_result   <= w_res;
            r_zero     <= (w_res == '0);
            r_parity   <= ^w_res;
        end else if (w_out_xfer) begin
            r_s2_valid <= 1'b0;
        end
    end

    // The accumulator commits when the op leaves S1, so a following ACC in S1 sees it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_mv12) begin
            if (r_s1_op == OP_ACC) begin
                r_acc <= w_res;
            end else if (r_s1_op == OP_CLR) begin
                r_acc <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_count <= '0;
        end else if (w_out_xfer) begin
            r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign parity    = r_parity;
    assign acc       = r_acc;
    assign op_count  = r_op_count;

endmodule
